// File: rtl/sram_req_arbiter_if.sv
// Bus bundle for sram_req_arbiter: the fetch channel, the data channel and
// the shared sram-like memory port. The arbiter uses the slave modport; the
// surrounding pipeline / bus bridge (or a testbench) uses the master modport.
interface sram_req_arbiter_if;
    // Fetch requester (read-only)
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    // Data requester (read/write)
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // Shared memory port
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    // Requester / memory side
    modport master (
        output inst_req, inst_addr, inst_cancel,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like memory port between the fetch
// requester (read-only) and the data requester (read/write).
// - Grant, mem_* drive and response routing are combinational (no added latency).
// - An in-order FIFO of {requester id, cancel} tracks outstanding transactions
//   so each mem_data_ok pulse is routed back to whoever issued it.
// - inst_cancel marks every owed fetch response as stale; stale responses are
//   consumed silently.
// - An address offered but not yet accepted locks the port to that requester
//   so the memory sees a stable address until mem_addr_ok.
// Optional feature: define ARB_RR_EN for round-robin arbitration between the
// two requesters; without it data always has priority over fetch.
module sram_req_arbiter #(
    parameter int OST_DEPTH = 4,    // max outstanding transactions, power of 2, >= 2
    parameter int OST_AW    = 2     // log2(OST_DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    sram_req_arbiter_if.slave  bus
);

    // Requester identifiers as stored in the outstanding FIFO
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [OST_AW-1:0] PTR_ONE   = OST_AW'(1);
    localparam logic [OST_AW:0]   CNT_ONE   = (OST_AW+1)'(1);
    localparam logic [OST_AW:0]   CNT_FULL  = (OST_AW+1)'(OST_DEPTH);

    // Address-phase lock: which requester (if any) has an address on the
    // memory port that has not been accepted yet.
    typedef enum logic [1:0] {
        LK_IDLE = 2'd0,
        LK_INST = 2'd1,
        LK_DATA = 2'd2
    } lock_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lock_state_t             r_lock_state;
    logic [OST_DEPTH-1:0]    r_fifo_id;
    logic [OST_DEPTH-1:0]    r_fifo_cancel;
    logic [OST_AW-1:0]       r_wptr;
    logic [OST_AW-1:0]       r_rptr;
    logic [OST_AW:0]         r_count;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                    w_full;
    logic                    w_empty;
    logic                    w_lock_hold;
    logic                    w_lock_id;
    logic                    w_any_req;
    logic                    w_win;
    logic                    w_tie_win;
    logic                    w_mem_req;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_head_id;
    logic                    w_head_cancel;
    logic [31:0]             w_mem_addr;
    logic                    w_mem_wr;
    logic [3:0]              w_mem_wstrb;
    logic [31:0]             w_mem_wdata;
    logic [OST_DEPTH-1:0]    w_entry_valid;
    logic [OST_DEPTH-1:0]    w_fifo_id_next;
    logic [OST_DEPTH-1:0]    w_fifo_cancel_next;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // ------------------------------------------------------------------
    // Tie-break between simultaneous requesters
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    // r_rr_next holds the requester that wins the next tie; it flips to the
    // other requester after every accepted address. Reset favours fetch.
    logic r_rr_next;

    // Round-robin pointer update on every accepted address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_next <= ID_INST;
        end else if (w_push) begin
            r_rr_next <= ~w_win;
        end
    end

    assign w_tie_win = r_rr_next;
`else
    // Fixed priority: data beats fetch.
    assign w_tie_win = ID_DATA;
`endif

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    // A lock only holds while its owner is still requesting; an abandoned
    // lock falls back to normal arbitration in the same cycle.
    always_comb begin
        w_lock_id   = (r_lock_state == LK_DATA) ? ID_DATA : ID_INST;
        w_lock_hold = ((r_lock_state == LK_INST) && bus.inst_req) ||
                      ((r_lock_state == LK_DATA) && bus.data_req);
        w_win       = ID_INST;
        w_any_req   = 1'b0;
        if (w_lock_hold) begin
            w_win     = w_lock_id;
            w_any_req = 1'b1;
        end else if (bus.data_req && bus.inst_req) begin
            w_win     = w_tie_win;
            w_any_req = 1'b1;
        end else if (bus.data_req) begin
            w_win     = ID_DATA;
            w_any_req = 1'b1;
        end else if (bus.inst_req) begin
            w_win     = ID_INST;
            w_any_req = 1'b1;
        end
    end

    // No request is offered while the FIFO is full, even if a response is
    // retiring an entry this cycle: the freed slot is usable next cycle.
    assign w_mem_req = rstn & w_any_req & ~w_full;
    assign w_push    = w_mem_req & bus.mem_addr_ok;
    // A response with nothing outstanding is ignored.
    assign w_pop     = rstn & bus.mem_data_ok & ~w_empty;

    // Memory-port fields follow the winner; everything is 0 when idle and a
    // fetch winner never writes.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wr    = 1'b0;
        w_mem_wstrb = '0;
        w_mem_wdata = '0;
        if (w_mem_req) begin
            if (w_win == ID_DATA) begin
                w_mem_addr  = bus.data_addr;
                w_mem_wr    = bus.data_wr;
                w_mem_wstrb = bus.data_wr ? bus.data_wstrb : 4'h0;
                w_mem_wdata = bus.data_wdata;
            end else begin
                w_mem_addr  = bus.inst_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    // Lock onto the winner while its address waits for mem_addr_ok; release
    // on acceptance, on abandonment, or when nothing is offered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock_state <= LK_IDLE;
        end else begin
            if (w_mem_req && !bus.mem_addr_ok) begin
                r_lock_state <= (w_win == ID_DATA) ? LK_DATA : LK_INST;
            end else begin
                r_lock_state <= LK_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding FIFO entries
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < OST_DEPTH; gi++) begin : g_entry
            logic [OST_AW-1:0] w_offset;

            // Distance of this slot from the head decides whether it holds
            // a live transaction.
            assign w_offset          = OST_AW'(gi) - r_rptr;
            assign w_entry_valid[gi] = ({1'b0, w_offset} < r_count);

            // A freshly pushed fetch is already stale if cancel arrives in
            // the same cycle; live fetch entries become stale on cancel;
            // data entries are never cancelled.
            always_comb begin
                w_fifo_id_next[gi]     = r_fifo_id[gi];
                w_fifo_cancel_next[gi] = r_fifo_cancel[gi];
                if (w_push && (r_wptr == OST_AW'(gi))) begin
                    w_fifo_id_next[gi]     = w_win;
                    w_fifo_cancel_next[gi] = (w_win == ID_INST) & bus.inst_cancel;
                end else if (bus.inst_cancel && w_entry_valid[gi] &&
                             (r_fifo_id[gi] == ID_INST)) begin
                    w_fifo_cancel_next[gi] = 1'b1;
                end
            end
        end
    endgenerate

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo_id     <= '0;
            r_fifo_cancel <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_fifo_id     <= w_fifo_id_next;
            r_fifo_cancel <= w_fifo_cancel_next;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // A cancel arriving in the same cycle as the head's response still
    // suppresses it.
    assign w_head_id     = r_fifo_id[r_rptr];
    assign w_head_cancel = r_fifo_cancel[r_rptr] | bus.inst_cancel;

    // ------------------------------------------------------------------
    // Outputs (all 0 while reset is asserted)
    // ------------------------------------------------------------------
    assign bus.mem_req      = w_mem_req;
    assign bus.mem_wr       = w_mem_wr;
    assign bus.mem_wstrb    = w_mem_wstrb;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;

    assign bus.inst_addr_ok = w_push & (w_win == ID_INST);
    assign bus.data_addr_ok = w_push & (w_win == ID_DATA);

    assign bus.inst_data_ok = w_pop & (w_head_id == ID_INST) & ~w_head_cancel;
    assign bus.data_data_ok = w_pop & (w_head_id == ID_DATA);

    assign bus.inst_rdata   = rstn ? bus.mem_rdata : 32'h0;
    assign bus.data_rdata   = rstn ? bus.mem_rdata : 32'h0;

`ifndef SYNTHESIS
    // Flag a memory response that has no outstanding transaction to match.
    always @(posedge clk) begin
        if (rstn && bus.mem_data_ok && w_empty) begin
            $error("sram_req_arbiter: mem_data_ok with no outstanding transaction");
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: directed scenarios followed by randomized
// traffic, every cycle checked against a queue-based reference model of the
// arbitration and response-routing rules.
module tb_sram_req_arbiter;

    localparam int OST_DEPTH = 4;

    logic clk;
    logic rstn;

    sram_req_arbiter_if bus ();

    sram_req_arbiter #(.OST_DEPTH(OST_DEPTH), .OST_AW(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: outstanding transactions in issue order
    bit q_id[$];       // 1 = data, 0 = inst
    bit q_can[$];      // fetch response to be discarded
    bit m_lock;        // an unaccepted address is pending
    bit m_lock_id;
    bit m_rr;          // requester favoured on the next tie

    // Observed outputs from the most recent step
    logic        o_mreq, o_mwr, o_iaok, o_daok, o_idok, o_ddok;
    logic [3:0]  o_mwstrb;
    logic [31:0] o_maddr, o_mwdata, o_irdata, o_drdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = 32'h0;
        bus.inst_cancel = 1'b0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_wstrb  = 4'h0;
        bus.data_addr   = 32'h0;
        bus.data_wdata  = 32'h0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
    endtask

    // One clock cycle: inputs are already driven (posedge+1); outputs are
    // sampled mid-cycle, compared with the model, and the model advances.
    task automatic step();
        bit          full, hold, win, mreq, acc, hid, hcan;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [3:0]  e_wstrb;
        logic        e_wr, e_iaok, e_daok, e_idok, e_ddok;
        #2;
        o_mreq = bus.mem_req;       o_mwr    = bus.mem_wr;
        o_mwstrb = bus.mem_wstrb;   o_maddr  = bus.mem_addr;
        o_mwdata = bus.mem_wdata;   o_iaok   = bus.inst_addr_ok;
        o_daok = bus.data_addr_ok;  o_idok   = bus.inst_data_ok;
        o_ddok = bus.data_data_ok;  o_irdata = bus.inst_rdata;
        o_drdata = bus.data_rdata;

        e_addr = 0; e_wdata = 0; e_wstrb = 0; e_wr = 0; e_rd = 0;
        e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; mreq = 0; win = 0;
        if (!rstn) begin
            q_id.delete(); q_can.delete();
            m_lock = 0; m_lock_id = 0; m_rr = 0;
        end else begin
            full = (q_id.size() == OST_DEPTH);
            hold = m_lock && (m_lock_id ? bus.data_req : bus.inst_req);
            if (!full) begin
                if (hold) begin
                    win = m_lock_id; mreq = 1;
                end else if (bus.data_req && bus.inst_req) begin
`ifdef ARB_RR_EN
                    win = m_rr;
`else
                    win = 1;
`endif
                    mreq = 1;
                end else if (bus.data_req || bus.inst_req) begin
                    win = bus.data_req; mreq = 1;
                end
            end
            if (mreq) begin
                e_addr  = win ? bus.data_addr : bus.inst_addr;
                e_wr    = win ? bus.data_wr : 1'b0;
                e_wstrb = (win && bus.data_wr) ? bus.data_wstrb : 4'h0;
                e_wdata = win ? bus.data_wdata : 32'h0;
            end
            acc    = mreq && bus.mem_addr_ok;
            e_iaok = acc && !win;
            e_daok = acc && win;
            e_rd   = bus.mem_rdata;
            if (bus.mem_data_ok && q_id.size() > 0) begin
                hid  = q_id.pop_front();
                hcan = q_can.pop_front() | bus.inst_cancel;
                e_ddok = hid;
                e_idok = !hid && !hcan;
            end
            if (bus.inst_cancel)
                foreach (q_id[i]) if (!q_id[i]) q_can[i] = 1;
            if (acc) begin
                q_id.push_back(win);
                q_can.push_back(!win && bus.inst_cancel);
                m_rr = !win;
            end
            m_lock    = mreq && !acc;
            m_lock_id = win;
        end

        chk("mem_req",      32'(o_mreq),   32'(mreq));
        chk("mem_wr",       32'(o_mwr),    32'(e_wr));
        chk("mem_wstrb",    32'(o_mwstrb), 32'(e_wstrb));
        chk("mem_addr",     o_maddr,       e_addr);
        chk("mem_wdata",    o_mwdata,      e_wdata);
        chk("inst_addr_ok", 32'(o_iaok),   32'(e_iaok));
        chk("data_addr_ok", 32'(o_daok),   32'(e_daok));
        chk("inst_data_ok", 32'(o_idok),   32'(e_idok));
        chk("data_data_ok", 32'(o_ddok),   32'(e_ddok));
        chk("inst_rdata",   o_irdata,      e_rd);
        chk("data_rdata",   o_drdata,      e_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state with a request pending: everything silent
        bus.inst_req = 1; bus.data_req = 1; bus.mem_addr_ok = 1;
        step();
        chk("rst_mem_req", 32'(o_mreq), 32'd0);
        rstn = 1'b1;
        idle();
        step();

        // Single fetch, response two cycles later
        bus.inst_req = 1; bus.inst_addr = 32'h1c000000; bus.mem_addr_ok = 1;
        step();
        chk("t1_iaok", 32'(o_iaok), 32'd1);
        chk("t1_addr", o_maddr, 32'h1c000000);
        idle(); step();
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h02800000;
        step();
        chk("t1_idok", 32'(o_idok), 32'd1);
        chk("t1_rdata", o_irdata, 32'h02800000);
        chk("t1_ddok", 32'(o_ddok), 32'd0);
        idle(); step();

        // Both request; write held off by mem_addr_ok for 3 cycles
        bus.inst_req = 1; bus.inst_addr = 32'h1c000040;
        bus.data_req = 1; bus.data_wr = 1; bus.data_wstrb = 4'hf;
        bus.data_addr = 32'h1c001000; bus.data_wdata = 32'hdeadbeef;
        for (int k = 0; k < 4; k++) begin
            bus.mem_addr_ok = (k == 3);
            step();
            chk("t2_addr", o_maddr, 32'h1c001000);
            chk("t2_wr", 32'(o_mwr), 32'd1);
            chk("t2_wdata", o_mwdata, 32'hdeadbeef);
            chk("t2_daok", 32'(o_daok), 32'(k == 3));
        end
        bus.data_req = 0;
        step();
        chk("t2_iaok", 32'(o_iaok), 32'd1);
        chk("t2_iaddr", o_maddr, 32'h1c000040);
        idle();
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h11;
        step();
        chk("t2_wr_done", 32'(o_ddok), 32'd1);
        bus.mem_rdata = 32'h22;
        step();
        chk("t2_fetch", 32'(o_idok), 32'd1);
        idle(); step();

        // Fill the FIFO with 4 fetches, then a 5th waits for a free slot
        bus.inst_req = 1; bus.mem_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            bus.inst_addr = 32'h100 + 32'(4 * k);
            step();
            chk("t3_iaok", 32'(o_iaok), 32'd1);
        end
        bus.inst_addr = 32'h200;
        step();
        chk("t3_full", 32'(o_mreq), 32'd0);
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h33;
        step();
        chk("t3_full_pop", 32'(o_mreq), 32'd0);
        chk("t3_pop_ok", 32'(o_idok), 32'd1);
        bus.mem_data_ok = 0;
        step();
        chk("t3_grant", 32'(o_iaok), 32'd1);
        chk("t3_addr", o_maddr, 32'h200);
        idle();
        bus.mem_data_ok = 1;
        for (int k = 0; k < 4; k++) step();
        idle(); step();

        // Cancel two owed fetches, then a data read
        bus.inst_req = 1; bus.mem_addr_ok = 1; bus.inst_addr = 32'h300;
        step(); step();
        idle(); bus.inst_cancel = 1;
        step();
        idle(); bus.data_req = 1; bus.data_addr = 32'h400; bus.mem_addr_ok = 1;
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            bus.mem_data_ok = 1; bus.mem_rdata = 32'ha1 + 32'(k);
            step();
            chk("t4_idok", 32'(o_idok), 32'd0);
            chk("t4_ddok", 32'(o_ddok), 32'(k == 2));
        end
        chk("t4_rdata", o_drdata, 32'ha3);
        idle(); step();

        // Both requesting continuously with immediate acceptance
        bus.inst_req = 1; bus.inst_addr = 32'h500;
        bus.data_req = 1; bus.data_addr = 32'h600; bus.mem_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef ARB_RR_EN
            chk("t5_rr", 32'(o_daok), 32'(k % 2));
`else
            chk("t5_fixed", 32'(o_daok), 32'd1);
`endif
        end
        idle(); bus.mem_data_ok = 1;
        for (int k = 0; k < 4; k++) step();
        idle(); step();

        // Reset with 3 data reads outstanding
        bus.data_req = 1; bus.data_addr = 32'h700; bus.mem_addr_ok = 1;
        step(); step(); step();
        bus.inst_req = 1;
        rstn = 1'b0;
        step();
        chk("t6_rst_req", 32'(o_mreq), 32'd0);
        chk("t6_rst_daok", 32'(o_daok), 32'd0);
        rstn = 1'b1;
        idle();
        bus.inst_req = 1; bus.inst_addr = 32'h800; bus.mem_addr_ok = 1;
        step();
        idle(); bus.mem_data_ok = 1; bus.mem_rdata = 32'h55;
        step();
        chk("t6_idok", 32'(o_idok), 32'd1);
        chk("t6_ddok", 32'(o_ddok), 32'd0);
        idle(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rstn            = ($urandom_range(0, 499) != 0);
            bus.inst_req    = ($urandom_range(0, 3) != 0);
            bus.inst_addr   = $urandom;
            bus.inst_cancel = ($urandom_range(0, 15) == 0);
            bus.data_req    = ($urandom_range(0, 2) == 0);
            bus.data_wr     = $urandom_range(0, 1);
            bus.data_wstrb  = 4'($urandom);
            bus.data_addr   = $urandom;
            bus.data_wdata  = $urandom;
            bus.mem_addr_ok = ($urandom_range(0, 2) != 0);
            bus.mem_data_ok = (q_id.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.mem_rdata   = $urandom;
            step();
        end
        rstn = 1'b1;
        idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
